// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl -- central pipeline stall / flush controller
//
// Arbitrates stall requests (mem > id > if) into a per-stage hold vector,
// sequences branch flushes so a flush is never lost behind an EX hold,
// marks the in-flight fetch to be discarded after a flush, and flags stall
// runs that reach MAX_STALL.
//
// Ports:
//   clk              system clock
//   rst              synchronous reset, active-low (0 = reset)
//   stallreq_if      instruction fetch not yet returned
//   stallreq_id      load-use hazard in ID
//   stallreq_mem     data memory access busy
//   branch_i         EX resolved a taken branch/jump (held while EX held)
//   stall_o[5:0]     per-stage hold {WB,MEM,EX,ID,IF,PC}, 1 = stop (comb)
//   flush_o          single-cycle kill of if_id / id_exe (comb)
//   drop_fetch_o     discard the next fetch response (registered)
//   stall_timeout_o  sticky flag: stall run reached MAX_STALL (registered)
//
// Optional build macro STALL_PERF_EN adds 32-bit wrapping event counters:
//   perf_mem_o, perf_id_o, perf_if_o (cycles each source won priority)
//   perf_flush_o (flush_o pulses)
// ---------------------------------------------------------------------------
module pipe_stall_ctrl #(
  parameter int unsigned MAX_STALL = 1024,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stallreq_if,
  input  logic       stallreq_id,
  input  logic       stallreq_mem,
  input  logic       branch_i,
  output logic [5:0] stall_o,
  output logic       flush_o,
  output logic       drop_fetch_o,
  output logic       stall_timeout_o
`ifdef STALL_PERF_EN
  ,
  output logic [31:0] perf_mem_o,
  output logic [31:0] perf_id_o,
  output logic [31:0] perf_if_o,
  output logic [31:0] perf_flush_o
`endif
);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_FLUSH_WAIT = 2'd1,
    S_DROP_FETCH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STALL);

  state_t           r_state;
  logic             r_drop;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       w_stall;
  logic             w_flush;

  // Priority stall vector; WB is never held, everything forced off in reset
  always_comb begin
    w_stall = 6'b000000;
    if (rst) begin
      if (stallreq_mem)      w_stall = 6'b011111;
      else if (stallreq_id)  w_stall = 6'b000111;
      else if (stallreq_if)  w_stall = 6'b000011;
    end
  end

  // Flush fires once EX is free; a deferred flush ignores the held branch_i
  always_comb begin
    w_flush = 1'b0;
    if (rst) begin
      case (r_state)
        S_RUN, S_DROP_FETCH: w_flush = branch_i & ~w_stall[3];
        S_FLUSH_WAIT:        w_flush = ~w_stall[3];
        default:             w_flush = 1'b0;
      endcase
    end
  end

  // Flush sequencing FSM; drop flag is registered alongside the state
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_RUN;
      r_drop  <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (branch_i) begin
            if (w_stall[3]) begin
              r_state <= S_FLUSH_WAIT;
            end else if (stallreq_if) begin
              r_state <= S_DROP_FETCH;
              r_drop  <= 1'b1;
            end
          end
        end
        S_FLUSH_WAIT: begin
          if (!w_stall[3]) begin
            if (stallreq_if) begin
              r_state <= S_DROP_FETCH;
              r_drop  <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_DROP_FETCH: begin
          // A fresh flush here re-arms the drop; otherwise leave once the
          // stale response has returned
          if (!(branch_i && !w_stall[3]) && !stallreq_if) begin
            r_state <= S_RUN;
            r_drop  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_RUN;
          r_drop  <= 1'b0;
        end
      endcase
    end
  end

  // Stall run-length counter (saturating) and sticky timeout flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_stall == 6'b000000)  r_cnt <= '0;
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
      if (r_cnt == CNT_MAX)      r_timeout <= 1'b1;
    end
  end

  assign stall_o         = w_stall;
  assign flush_o         = w_flush;
  assign drop_fetch_o    = r_drop;
  assign stall_timeout_o = r_timeout;

`ifdef STALL_PERF_EN
  logic [31:0] r_perf_mem;
  logic [31:0] r_perf_id;
  logic [31:0] r_perf_if;
  logic [31:0] r_perf_flush;

  // Winner decode follows the priority shape of the stall vector
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_mem   <= '0;
      r_perf_id    <= '0;
      r_perf_if    <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_stall[4])               r_perf_mem   <= r_perf_mem + 32'd1;
      if (w_stall[2] && !w_stall[3]) r_perf_id   <= r_perf_id + 32'd1;
      if (w_stall[1] && !w_stall[2]) r_perf_if   <= r_perf_if + 32'd1;
      if (w_flush)                  r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_mem_o   = r_perf_mem;
  assign perf_id_o    = r_perf_id;
  assign perf_if_o    = r_perf_if;
  assign perf_flush_o = r_perf_flush;
`endif

endmodule
